// File: rtl/st_pack_if.sv
// st_pack_if
//   Groups the store request handshake, the data-bus write channel and the
//   completion/exception pulses of the store-side packer.
//   slave  : the packer's view (takes requests, drives the bus and the pulses)
//   master : the view of whatever issues requests and serves the bus
//   Signals:
//     req_valid/req_ready     store request handshake
//     req_op[1:0]             0=SW 1=SH 2=SB 3=reserved
//     req_addr[31:0]          byte address
//     req_data[31:0]          register data
//     bus_valid/bus_ready     write transfer handshake
//     bus_addr[31:0]          word-aligned bus address
//     bus_wdata[31:0]         lane-replicated write data
//     bus_byteen[3:0]         byte enables
//     done/exc_ades/bus_err   one-cycle status pulses
interface st_pack_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        done;
    logic        exc_ades;
    logic        bus_err;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, bus_ready,
        output req_ready, bus_valid, bus_addr, bus_wdata, bus_byteen,
               done, exc_ades, bus_err
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, bus_ready,
        input  req_ready, bus_valid, bus_addr, bus_wdata, bus_byteen,
               done, exc_ades, bus_err
    );
endinterface

// File: rtl/st_pack.sv
// st_pack
//   Store-side data packer. Accepts one SW/SH/SB request at a time, rejects
//   misaligned or out-of-range stores with an AdES pulse, otherwise issues a
//   single registered word-aligned write with byte enables and replicated lane
//   data. A wait counter aborts a transfer the bus never accepts.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bif    st_pack_if.slave (request handshake, bus write channel, pulses)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a request; AdES decided in the accept cycle
//   ISSUE | bus_valid high, bus_* held, counting cycles without bus_ready
module st_pack #(
    parameter logic [31:0] DM_LAST = 32'h0000_2FFF,
    parameter logic [31:0] IO_BASE = 32'h0000_7F00,
    parameter logic [31:0] IO_LAST = 32'h0000_7F23,
    parameter int          TIMEOUT = 8
) (
    input  logic     clk,
    input  logic     reset,
    st_pack_if.slave bif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    // Counter only has to reach TIMEOUT-1.
    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_TC = CW'(TIMEOUT - 1);

    localparam logic [1:0] OP_SW = 2'd0;
    localparam logic [1:0] OP_SH = 2'd1;
    localparam logic [1:0] OP_SB = 2'd2;

    logic [0:0]    state;
    logic [CW-1:0] wait_cnt;

    logic          in_dm;
    logic          in_io;
    logic          ades;
    logic [31:0]   pk_wdata;
    logic [3:0]    pk_byteen;

    assign bif.req_ready = (state == IDLE);

    // Address check and lane packing for the request currently presented.
    always_comb begin
        in_dm     = (bif.req_addr <= DM_LAST);
        in_io     = (bif.req_addr >= IO_BASE) && (bif.req_addr <= IO_LAST);
        ades      = 1'b0;
        pk_wdata  = 32'h0;
        pk_byteen = 4'h0;
        case (bif.req_op)
            OP_SW: begin
                ades      = (bif.req_addr[1:0] != 2'b00) || !(in_dm || in_io);
                pk_wdata  = bif.req_data;
                pk_byteen = 4'b1111;
            end
            OP_SH: begin
                // Halfword and byte stores are only legal in data memory.
                ades      = bif.req_addr[0] || !in_dm;
                pk_wdata  = {2{bif.req_data[15:0]}};
                pk_byteen = bif.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                ades      = !in_dm;
                pk_wdata  = {4{bif.req_data[7:0]}};
                pk_byteen = 4'b0001 << bif.req_addr[1:0];
            end
            default: begin
                ades = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            bif.bus_valid  <= 1'b0;
            bif.bus_addr   <= 32'h0;
            bif.bus_wdata  <= 32'h0;
            bif.bus_byteen <= 4'h0;
            bif.done       <= 1'b0;
            bif.exc_ades   <= 1'b0;
            bif.bus_err    <= 1'b0;
        end else begin
            bif.done     <= 1'b0;
            bif.exc_ades <= 1'b0;
            bif.bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bif.req_valid) begin
                        if (ades) begin
                            bif.exc_ades <= 1'b1;
                        end else begin
                            state          <= ISSUE;
                            wait_cnt       <= '0;
                            bif.bus_valid  <= 1'b1;
                            bif.bus_addr   <= {bif.req_addr[31:2], 2'b00};
                            bif.bus_wdata  <= pk_wdata;
                            bif.bus_byteen <= pk_byteen;
                        end
                    end
                end
                ISSUE: begin
                    // bus_ready in the terminal cycle still completes the transfer.
                    if (bif.bus_ready || (wait_cnt == WAIT_TC)) begin
                        state          <= IDLE;
                        wait_cnt       <= '0;
                        bif.bus_valid  <= 1'b0;
                        bif.bus_addr   <= 32'h0;
                        bif.bus_wdata  <= 32'h0;
                        bif.bus_byteen <= 4'h0;
                        bif.done       <= bif.bus_ready;
                        bif.bus_err    <= !bif.bus_ready;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_st_pack.sv
module tb_st_pack;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    st_pack_if bif();

    st_pack #(
        .DM_LAST (32'h0000_2FFF),
        .IO_BASE (32'h0000_7F00),
        .IO_LAST (32'h0000_7F23),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog");
    end

    // Stimulus only: present a request on the request channel.
    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        bif.req_valid = 1'b1;
        bif.req_op    = op;
        bif.req_addr  = a;
        bif.req_data  = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_op    = 2'd0;
        bif.req_addr  = 32'h0;
        bif.req_data  = 32'h0;
        bif.bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bif.req_ready); end
        checks++; if (bif.bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid got %b exp 0", bif.bus_valid); end
        checks++; if ({bif.done, bif.exc_ades, bif.bus_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {bif.done, bif.exc_ades, bif.bus_err}); end
        checks++; if ({bif.bus_byteen, bif.bus_wdata, bif.bus_addr} !== 68'h0) begin errors++; $display("FAIL reset_bus_fields got %h/%h/%h exp 0", bif.bus_byteen, bif.bus_wdata, bif.bus_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sw_basic;
        bif.bus_ready = 1'b1;
        drive_req(2'd0, 32'h0000_0010, 32'hDEAD_BEEF);
        checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL sw_req_ready got %b exp 1", bif.req_ready); end
        @(negedge clk);
        bif.req_valid = 1'b0;
        checks++; if (bif.bus_valid !== 1'b1) begin errors++; $display("FAIL sw_bus_valid got %b exp 1", bif.bus_valid); end
        checks++; if (bif.bus_addr !== 32'h0000_0010) begin errors++; $display("FAIL sw_bus_addr got %h exp 00000010", bif.bus_addr); end
        checks++; if (bif.bus_byteen !== 4'b1111) begin errors++; $display("FAIL sw_byteen got %b exp 1111", bif.bus_byteen); end
        checks++; if (bif.bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", bif.bus_wdata); end
        checks++; if ({bif.req_ready, bif.done} !== 2'b00) begin errors++; $display("FAIL sw_issue_flags got %b exp 00", {bif.req_ready, bif.done}); end
        @(negedge clk);
        checks++; if (bif.done !== 1'b1) begin errors++; $display("FAIL sw_done got %b exp 1", bif.done); end
        checks++; if ({bif.bus_valid, bif.req_ready} !== 2'b01) begin errors++; $display("FAIL sw_after_done got %b exp 01", {bif.bus_valid, bif.req_ready}); end
        checks++; if ({bif.bus_byteen, bif.bus_wdata} !== 36'h0) begin errors++; $display("FAIL sw_idle_zero got %h/%h exp 0", bif.bus_byteen, bif.bus_wdata); end
        @(negedge clk);
        checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL sw_done_width got %b exp 0", bif.done); end
    endtask

    task automatic test_lanes;
        logic [1:0]  op   [6] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2};
        logic [31:0] addr [6] = '{32'h3, 32'h6, 32'h0, 32'h2FFF, 32'h7F20, 32'h1};
        logic [31:0] data [6] = '{32'hA5, 32'h1234_5678, 32'hFFFF_ABCD, 32'h11, 32'hCAFE_F00D, 32'h77};
        logic [31:0] e_ad [6] = '{32'h0, 32'h4, 32'h0, 32'h2FFC, 32'h7F20, 32'h0};
        logic [3:0]  e_be [6] = '{4'b1000, 4'b1100, 4'b0011, 4'b1000, 4'b1111, 4'b0010};
        logic [31:0] e_wd [6] = '{32'hA5A5_A5A5, 32'h5678_5678, 32'hABCD_ABCD, 32'h1111_1111, 32'hCAFE_F00D, 32'h7777_7777};
        bif.bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_req(op[i], addr[i], data[i]);
            @(negedge clk);
            bif.req_valid = 1'b0;
            checks++; if ({bif.bus_valid, bif.exc_ades} !== 2'b10) begin errors++; $display("FAIL lane%0d_valid got %b exp 10", i, {bif.bus_valid, bif.exc_ades}); end
            checks++; if (bif.bus_addr !== e_ad[i]) begin errors++; $display("FAIL lane%0d_addr got %h exp %h", i, bif.bus_addr, e_ad[i]); end
            checks++; if (bif.bus_byteen !== e_be[i]) begin errors++; $display("FAIL lane%0d_byteen got %b exp %b", i, bif.bus_byteen, e_be[i]); end
            checks++; if (bif.bus_wdata !== e_wd[i]) begin errors++; $display("FAIL lane%0d_wdata got %h exp %h", i, bif.bus_wdata, e_wd[i]); end
            @(negedge clk);
            checks++; if (bif.done !== 1'b1) begin errors++; $display("FAIL lane%0d_done got %b exp 1", i, bif.done); end
        end
    endtask

    task automatic test_ades;
        logic [1:0]  op   [7] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        logic [31:0] addr [7] = '{32'h5, 32'h3000, 32'h7F04, 32'h0, 32'h7F02, 32'h7F24, 32'h7F00};
        bif.bus_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_req(op[i], addr[i], 32'h5555_AAAA);
            @(negedge clk);
            bif.req_valid = 1'b0;
            checks++; if (bif.exc_ades !== 1'b1) begin errors++; $display("FAIL ades%0d_pulse got %b exp 1", i, bif.exc_ades); end
            checks++; if ({bif.bus_valid, bif.done, bif.bus_err, bif.req_ready} !== 4'b0001) begin errors++; $display("FAIL ades%0d_state got %b exp 0001", i, {bif.bus_valid, bif.done, bif.bus_err, bif.req_ready}); end
            @(negedge clk);
            checks++; if ({bif.exc_ades, bif.bus_valid} !== 2'b00) begin errors++; $display("FAIL ades%0d_after got %b exp 00", i, {bif.exc_ades, bif.bus_valid}); end
        end
    endtask

    // ready_at: ISSUE cycle (1..8) in which bus_ready goes high, 0 = never.
    task automatic run_timeout(input int ready_at, input string tag);
        bif.bus_ready = 1'b0;
        drive_req(2'd0, 32'h0000_7F00, 32'h0BAD_F00D);
        @(negedge clk);
        bif.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++; if ({bif.bus_valid, bif.done, bif.bus_err} !== 3'b100) begin errors++; $display("FAIL %s_cyc%0d got %b exp 100", tag, c, {bif.bus_valid, bif.done, bif.bus_err}); end
            if (c == ready_at) bif.bus_ready = 1'b1;
            @(negedge clk);
        end
        bif.bus_ready = 1'b0;
        if (ready_at == 0) begin
            checks++; if ({bif.bus_err, bif.done, bif.bus_valid, bif.req_ready} !== 4'b1001) begin errors++; $display("FAIL %s_abort got %b exp 1001", tag, {bif.bus_err, bif.done, bif.bus_valid, bif.req_ready}); end
            checks++; if ({bif.bus_byteen, bif.bus_wdata} !== 36'h0) begin errors++; $display("FAIL %s_abort_zero got %h/%h exp 0", tag, bif.bus_byteen, bif.bus_wdata); end
        end else begin
            checks++; if ({bif.bus_err, bif.done, bif.bus_valid, bif.req_ready} !== 4'b0101) begin errors++; $display("FAIL %s_late_ready got %b exp 0101", tag, {bif.bus_err, bif.done, bif.bus_valid, bif.req_ready}); end
        end
        @(negedge clk);
        checks++; if ({bif.bus_err, bif.done} !== 2'b00) begin errors++; $display("FAIL %s_pulse_width got %b exp 00", tag, {bif.bus_err, bif.done}); end
    endtask

    task automatic test_timeout;
        run_timeout(0, "tmo");
        run_timeout(8, "tmo_ready8");
    endtask

    task automatic test_back_to_back;
        bif.bus_ready = 1'b1;
        drive_req(2'd0, 32'h0000_0100, 32'h1111_1111);
        @(negedge clk);
        drive_req(2'd2, 32'h0000_0102, 32'h0000_00C3);
        checks++; if ({bif.bus_valid, bif.req_ready} !== 2'b10) begin errors++; $display("FAIL b2b_first got %b exp 10", {bif.bus_valid, bif.req_ready}); end
        checks++; if (bif.bus_wdata !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first_wdata got %h exp 11111111", bif.bus_wdata); end
        @(negedge clk);
        checks++; if ({bif.done, bif.bus_valid, bif.req_ready} !== 3'b101) begin errors++; $display("FAIL b2b_gap got %b exp 101", {bif.done, bif.bus_valid, bif.req_ready}); end
        @(negedge clk);
        bif.req_valid = 1'b0;
        checks++; if ({bif.bus_valid, bif.bus_byteen} !== 5'b1_0100) begin errors++; $display("FAIL b2b_second got %b exp 10100", {bif.bus_valid, bif.bus_byteen}); end
        checks++; if ({bif.bus_addr, bif.bus_wdata} !== {32'h0000_0100, 32'hC3C3_C3C3}) begin errors++; $display("FAIL b2b_second_data got %h/%h exp 00000100/c3c3c3c3", bif.bus_addr, bif.bus_wdata); end
        @(negedge clk);
        checks++; if (bif.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", bif.done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue;
        bif.bus_ready = 1'b0;
        drive_req(2'd0, 32'h0000_0040, 32'h0F0F_0F0F);
        @(negedge clk);
        bif.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bif.bus_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b exp 1", bif.bus_valid); end
        reset = 1'b1;
        #1;
        checks++; if ({bif.bus_valid, bif.req_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_async got %b exp 01", {bif.bus_valid, bif.req_ready}); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({bif.done, bif.bus_err, bif.exc_ades} !== 3'b000) begin errors++; $display("FAIL rst_mid_pulses got %b exp 000", {bif.done, bif.bus_err, bif.exc_ades}); end
        @(negedge clk);
        checks++; if ({bif.req_ready, bif.bus_valid, bif.done, bif.bus_err} !== 4'b1000) begin errors++; $display("FAIL rst_mid_release got %b exp 1000", {bif.req_ready, bif.bus_valid, bif.done, bif.bus_err}); end
        // A fresh transfer after reset must see a full wait budget again.
        run_timeout(0, "tmo_after_rst");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_sw_basic;
        test_lanes;
        test_ades;
        test_timeout;
        test_back_to_back;
        test_reset_mid_issue;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
